// File: rtl/turbo_encoder_core_pkg.sv
//==============================================================================
// Module      : turbo_pkg
// Description : Shared definitions for the turbo encoder core: FSM state
//               codes, RSC generator polynomials, tail length and the
//               conditional-subtract modulo step used by the QPP interleaver.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package turbo_pkg;

    // Top-level FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_LOAD   = 2'd0;
    localparam state_t ST_ENCODE = 2'd1;
    localparam state_t ST_TAIL   = 2'd2;

    // RSC generators (octal): G0 is feedback, G1 is feed-forward.
    // Bit 3 is the current input/feedback tap, bits 2..0 weight s1..s3.
    localparam logic [3:0] G0 = 4'o13;
    localparam logic [3:0] G1 = 4'o15;

    // Three termination words per constituent encoder
    localparam int unsigned TAIL_LEN = 6;

    // (a + b) mod k for operands already in [0, k): one conditional subtract.
    function automatic int unsigned qpp_step(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned k);
        int unsigned s;
        s = a + b;
        if (s >= k) begin
            s = s - k;
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/turbo_encoder_core_rsc.sv
//==============================================================================
// Module      : rsc_encoder_k4
// Description : 8-state recursive systematic convolutional encoder
//               (feedback G0, feed-forward G1). In terminate mode the input
//               is replaced by the feedback value so the register drains to 0.
// Ports       : clk, rst (async active-low)
//               i_u       - data input bit (normal mode)
//               i_term    - 1: termination mode (input = feedback)
//               i_advance - shift the state register this cycle
//               i_clear   - synchronously force state to zero
//               o_parity  - parity output for the current state/input
//               o_sys     - effective systematic bit (i_u or tail bit)
//               o_state   - {s3, s2, s1}
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rsc_encoder_k4
    import turbo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_u,
    input  logic       i_term,
    input  logic       i_advance,
    input  logic       i_clear,
    output logic       o_parity,
    output logic       o_sys,
    output logic [2:0] o_state
);

    // r_s[0] = s1 (most recent), r_s[2] = s3 (oldest)
    logic [2:0] r_s;
    logic       w_fb;
    logic       w_u;
    logic       w_a;

    assign w_fb = (G0[2] & r_s[0]) ^ (G0[1] & r_s[1]) ^ (G0[0] & r_s[2]);
    // Feeding the feedback back in forces a = 0, shifting zeros in.
    assign w_u  = i_term ? w_fb : i_u;
    assign w_a  = w_u ^ w_fb;

    assign o_parity = (G1[3] & w_a) ^ (G1[2] & r_s[0]) ^ (G1[1] & r_s[1])
                    ^ (G1[0] & r_s[2]);
    assign o_sys    = w_u;
    assign o_state  = r_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s <= 3'b000;
        end else if (i_clear) begin
            r_s <= 3'b000;
        end else if (i_advance) begin
            r_s <= {r_s[1], r_s[0], w_a};
        end
    end

endmodule

`default_nettype wire

// File: rtl/turbo_encoder_core.sv
//==============================================================================
// Module      : turbo_encoder_core
// Description : Parallel-concatenated turbo encoder. Loads a K-bit block
//               serially, then emits K words {sys, p1, p2} followed by six
//               trellis-termination words. RSC2 reads the buffer through a
//               recursively computed QPP interleaver pi(i)=(F1*i+F2*i^2)%K.
// Ports       : clk, rst (async active-low)
//               serial_in/in_valid/in_ready     - serial block input
//               encoded_data/out_valid/out_ready - 3-bit output words
//               out_last  - final tail word of the block
//               busy      - encoding or terminating
//               bit_count - LOAD write index / ENCODE read index
// Options     : TURBO_PUNCT_EN adds rate_half (in) and encoded_mask (out)
//               for rate-1/2 puncturing of the data words.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module turbo_encoder_core
    import turbo_pkg::*;
#(
    parameter  int K  = 8,
    parameter  int F1 = 3,
    parameter  int F2 = 2,
    localparam int AW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          serial_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [2:0]    encoded_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic [AW-1:0] bit_count
`ifdef TURBO_PUNCT_EN
    ,
    input  logic          rate_half,
    output logic [2:0]    encoded_mask
`endif
);

    localparam logic [AW-1:0] c_last_idx = AW'(K - 1);
    localparam logic [AW-1:0] c_g_init   = AW'((F1 + F2) % K);
    localparam logic [AW-1:0] c_g_inc    = AW'((2 * F2) % K);
    localparam logic [2:0]    c_tail_end = 3'(TAIL_LEN - 1);

    state_t        r_state;
    logic [AW-1:0] r_bit_count;
    logic [AW-1:0] r_pi;
    logic [AW-1:0] r_g;
    logic [2:0]    r_tail;
    logic [K-1:0]  r_buf;

    logic          w_wr;
    logic          w_busy;
    logic          w_accept;
    logic          w_tail1;
    logic          w_tail_last;
    logic          w_term;
    logic          w_adv1;
    logic          w_adv2;
    logic          w_clr;
    logic          w_u1;
    logic          w_u2;
    logic          w_sys1;
    logic          w_sys2;
    logic          w_p1;
    logic          w_p2;
    logic [2:0]    w_s1;
    logic [2:0]    w_s2;
    logic [2:0]    w_word;

    assign w_busy      = (r_state == ST_ENCODE) || (r_state == ST_TAIL);
    assign w_wr        = (r_state == ST_LOAD) && in_valid;
    assign w_accept    = w_busy && out_ready;
    assign w_tail1     = (r_state == ST_TAIL) && (r_tail < 3'd3);
    assign w_tail_last = (r_state == ST_TAIL) && (r_tail == c_tail_end);
    assign w_term      = (r_state == ST_TAIL);
    assign w_clr       = w_accept && w_tail_last;
    // RSC1 drains during tail words 0-2, RSC2 during 3-5; the other holds.
    assign w_adv1      = w_accept && ((r_state == ST_ENCODE) || w_tail1);
    assign w_adv2      = w_accept && ((r_state == ST_ENCODE) ||
                                      ((r_state == ST_TAIL) && !w_tail1));

    assign w_u1 = r_buf[r_bit_count];
    assign w_u2 = r_buf[r_pi];

    // Block buffer: contents are don't-care until rewritten, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_bit_count] <= serial_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_LOAD;
            r_bit_count <= '0;
            r_pi        <= '0;
            r_g         <= c_g_init;
            r_tail      <= 3'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_wr) begin
                        if (r_bit_count == c_last_idx) begin
                            r_state     <= ST_ENCODE;
                            r_bit_count <= '0;
                        end else begin
                            r_bit_count <= r_bit_count + 1'b1;
                        end
                    end
                end
                ST_ENCODE: begin
                    if (out_ready) begin
                        // pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*F2, all mod K
                        r_pi <= AW'(qpp_step(32'(r_pi), 32'(r_g), K));
                        r_g  <= AW'(qpp_step(32'(r_g), 32'(c_g_inc), K));
                        if (r_bit_count == c_last_idx) begin
                            r_state     <= ST_TAIL;
                            r_bit_count <= '0;
                            r_tail      <= 3'd0;
                        end else begin
                            r_bit_count <= r_bit_count + 1'b1;
                        end
                    end
                end
                ST_TAIL: begin
                    if (out_ready) begin
                        if (r_tail == c_tail_end) begin
                            r_state <= ST_LOAD;
                            r_tail  <= 3'd0;
                            r_pi    <= '0;
                            r_g     <= c_g_init;
                        end else begin
                            r_tail <= r_tail + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    rsc_encoder_k4 u_rsc1 (
        .clk       (clk),
        .rst       (rst),
        .i_u       (w_u1),
        .i_term    (w_term),
        .i_advance (w_adv1),
        .i_clear   (w_clr),
        .o_parity  (w_p1),
        .o_sys     (w_sys1),
        .o_state   (w_s1)
    );

    rsc_encoder_k4 u_rsc2 (
        .clk       (clk),
        .rst       (rst),
        .i_u       (w_u2),
        .i_term    (w_term),
        .i_advance (w_adv2),
        .i_clear   (w_clr),
        .o_parity  (w_p2),
        .o_sys     (w_sys2),
        .o_state   (w_s2)
    );

    always_comb begin
        w_word = 3'b000;
        case (r_state)
            ST_ENCODE: w_word = {w_sys1, w_p1, w_p2};
            ST_TAIL:   w_word = w_tail1 ? {w_sys1, w_p1, 1'b0}
                                        : {w_sys2, 1'b0, w_p2};
            default:   w_word = 3'b000;
        endcase
    end

    assign encoded_data = w_word;
    assign out_valid    = w_busy;
    assign busy         = w_busy;
    assign in_ready     = (r_state == ST_LOAD);
    assign out_last     = w_tail_last;
    assign bit_count    = r_bit_count;

`ifdef TURBO_PUNCT_EN
    logic r_rate_half;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rate_half <= 1'b0;
        end else if (w_wr && (r_bit_count == c_last_idx)) begin
            r_rate_half <= rate_half;
        end
    end

    // Rate 1/2: alternate which parity is kept on data words.
    always_comb begin
        encoded_mask = 3'b111;
        if ((r_state == ST_ENCODE) && r_rate_half) begin
            encoded_mask = r_bit_count[0] ? 3'b101 : 3'b110;
        end
    end
`endif

`ifndef SYNTHESIS
    // On the last tail word RSC1 is already drained and RSC2 must hold only
    // s3, which this final shift removes.
    always @(posedge clk) begin
        if (rst && w_clr) begin
            assert (w_s1 == 3'b000 && w_s2[1:0] == 2'b00);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_turbo_encoder_core.sv
`default_nettype none

module tb_turbo_encoder_core;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] encoded_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic [2:0] bit_count;
`ifdef TURBO_PUNCT_EN
    logic       rate_half;
    logic [2:0] encoded_mask;
    bit         toggle_rh;
    logic [2:0] got_m [14];
`endif

    int checks;
    int failures;

    logic [2:0] got_w [14];
    logic       got_l [14];

    typedef struct packed {
        logic [7:0]        data;
        logic [0:13][2:0]  words;
    } vec_t;

    vec_t vecs [4];
    int   pinv [8];

    turbo_encoder_core #(.K(8), .F1(3), .F2(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .encoded_data (encoded_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .bit_count    (bit_count)
`ifdef TURBO_PUNCT_EN
        ,
        .rate_half    (rate_half),
        .encoded_mask (encoded_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("in_ready_load%0d", i), 32'(in_ready), 32'd1);
            chk($sformatf("wr_index%0d", i), 32'(bit_count), 32'(i));
            in_valid  = 1'b1;
            serial_in = data[i];
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        serial_in = 1'b0;
    endtask

    // Loads a block, then collects all 14 output words into got_*.
    task automatic run_block(input logic [7:0] data, input bit stall);
        int waited;
        waited = 0;
        send_bits(data, 8);
        chk("first_word_latency", 32'(out_valid), 32'd1);
        if (stall) begin
            // Garbage input while in_ready is low must be ignored.
            in_valid  = 1'b1;
            serial_in = 1'b1;
        end
        for (int w = 0; w < 14; w++) begin
            int guard;
            logic [2:0] first;
            guard = 0;
            while (!out_valid && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            waited += guard;
            if (!out_valid) begin
                chk($sformatf("valid_timeout_w%0d", w), 32'(out_valid), 32'd1);
            end
            first = encoded_data;
            if (stall) begin
                int n;
                n = $urandom_range(0, 2);
                for (int s = 0; s < n; s++) begin
                    out_ready = 1'b0;
                    @(posedge clk); #1;
                    chk($sformatf("hold_w%0d", w), 32'(encoded_data), 32'(first));
                    chk($sformatf("stall_valid_w%0d", w), 32'(out_valid), 32'd1);
                    chk($sformatf("stall_in_ready_w%0d", w), 32'(in_ready), 32'd0);
                end
            end
            chk($sformatf("busy_w%0d", w), 32'(busy), 32'd1);
            chk($sformatf("in_ready_w%0d", w), 32'(in_ready), 32'd0);
            if (w < 8) begin
                chk($sformatf("rd_index_w%0d", w), 32'(bit_count), 32'(w));
            end
            got_w[w] = encoded_data;
            got_l[w] = out_last;
`ifdef TURBO_PUNCT_EN
            got_m[w] = encoded_mask;
            if (toggle_rh) rate_half = ~rate_half;
`endif
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        serial_in = 1'b0;
        if (!stall) begin
            chk("throughput_gaps", 32'(waited), 32'd0);
        end
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_bit_count", 32'(bit_count), 32'd0);
    endtask

    task automatic cmp_vec(input int v, input string tag);
        for (int w = 0; w < 14; w++) begin
            chk($sformatf("%s_v%0d_word%0d", tag, v, w), 32'(got_w[w]), 32'(vecs[v].words[w]));
            chk($sformatf("%s_v%0d_last%0d", tag, v, w), 32'(got_l[w]), (w == 13) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        serial_in = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef TURBO_PUNCT_EN
        rate_half = 1'b0;
        toggle_rh = 1'b0;
`endif

        // Words listed i=0..7 then tail 0..5, each {sys, p1, p2}
        vecs[0] = '{data: 8'h00, words: '0};
        vecs[1] = '{data: 8'h01, words: {3'b111, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 3'b011,
                                         3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b100, 3'b101}};
        vecs[2] = '{data: 8'h20, words: {3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b110, 3'b010,
                                         3'b011, 3'b100, 3'b100, 3'b110, 3'b101, 3'b000, 3'b000}};
        vecs[3] = '{data: 8'h21, words: {3'b111, 3'b010, 3'b010, 3'b010, 3'b001, 3'b110, 3'b001,
                                         3'b011, 3'b110, 3'b000, 3'b000, 3'b100, 3'b100, 3'b101}};
        // Inverse of pi = 0,5,6,3,4,1,2,7 (an involution for K=8)
        pinv = '{0, 5, 6, 3, 4, 1, 2, 7};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(encoded_data), 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven blocks without backpressure
        for (int v = 0; v < 4; v++) begin
            run_block(vecs[v].data, 1'b0);
            cmp_vec(v, "nostall");
        end

        // Interleaver: impulse at j reaches RSC2 at i = pi^-1(j)
        for (int j = 0; j < 8; j++) begin
            int f1;
            int f2;
            logic [7:0] d;
            d = 8'h01 << j;
            run_block(d, 1'b0);
            f1 = -1;
            f2 = -1;
            for (int w = 0; w < 8; w++) begin
                if (f1 < 0 && got_w[w][1]) f1 = w;
                if (f2 < 0 && got_w[w][0]) f2 = w;
            end
            chk($sformatf("perm_sys_j%0d", j), 32'(got_w[j][2]), 32'd1);
            chk($sformatf("perm_p1_j%0d", j), 32'(f1), 32'(j));
            chk($sformatf("perm_p2_j%0d", j), 32'(f2), 32'(pinv[j]));
        end

        // Random backpressure must not change the word sequence
        run_block(vecs[2].data, 1'b1);
        cmp_vec(2, "stall");
        run_block(vecs[3].data, 1'b1);
        cmp_vec(3, "stall");

        // Reset while loading bit 4
        send_bits(8'hFF, 4);
        in_valid  = 1'b1;
        serial_in = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        chk("rstload_in_ready", 32'(in_ready), 32'd1);
        chk("rstload_bit_count", 32'(bit_count), 32'd0);
        chk("rstload_busy", 32'(busy), 32'd0);
        in_valid  = 1'b0;
        serial_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        run_block(vecs[2].data, 1'b0);
        cmp_vec(2, "after_rstload");

        // Reset in the middle of ENCODE
        send_bits(vecs[1].data, 8);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_encode_index", 32'(bit_count), 32'd3);
        chk("mid_encode_word", 32'(encoded_data), 32'(vecs[1].words[3]));
        #2;
        rst = 1'b0;
        #1;
        chk("rstenc_out_valid", 32'(out_valid), 32'd0);
        chk("rstenc_data", 32'(encoded_data), 32'd0);
        chk("rstenc_busy", 32'(busy), 32'd0);
        chk("rstenc_out_last", 32'(out_last), 32'd0);
        chk("rstenc_in_ready", 32'(in_ready), 32'd1);
        chk("rstenc_bit_count", 32'(bit_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_block(vecs[3].data, 1'b0);
        cmp_vec(3, "after_rstenc");

`ifdef TURBO_PUNCT_EN
        // Rate 1/2, with rate_half toggling during the block
        rate_half = 1'b1;
        toggle_rh = 1'b1;
        run_block(vecs[1].data, 1'b0);
        cmp_vec(1, "punct");
        for (int w = 0; w < 14; w++) begin
            chk($sformatf("mask_half_w%0d", w), 32'(got_m[w]),
                (w >= 8) ? 32'd7 : ((w % 2 == 0) ? 32'd6 : 32'd5));
        end
        // Rate 1/3: mask all ones
        rate_half = 1'b0;
        toggle_rh = 1'b0;
        run_block(vecs[3].data, 1'b0);
        for (int w = 0; w < 14; w++) begin
            chk($sformatf("mask_third_w%0d", w), 32'(got_m[w]), 32'd7);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/turbo_encoder_core.md
Name: turbo_encoder_core

Overview:
Parametrised successor to the fixed 8-bit serial turbo encoder. Collects a K-bit block from a serial input into an internal block buffer. Encodes the block with two 8-state RSC encoders (g0=13, g1=15 octal). The second encoder reads the buffer through an on-the-fly QPP interleaver. After the data it appends trellis termination, and it sits between the serial source and the rate-matching/modulation stage.

Parameters:
K, 8, block length in bits (>=8; F1/F2 must give a valid QPP permutation for K)
F1, 3, QPP linear coefficient
F2, 2, QPP quadratic coefficient
AW, $clog2(K), buffer address / counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
serial_in  in  1  input data bit
in_valid  in  1  serial_in valid
in_ready  out  1  block can accept a bit
encoded_data  out  3  {sys, p1, p2}
out_valid  out  1  encoded_data valid
out_ready  in  1  downstream accepts encoded_data
out_last  out  1  marks final tail word of block
busy  out  1  high in ENCODE/TAIL
bit_count  out  AW  LOAD write index / ENCODE read index

Behaviour:
- Reset (rst=0, async): state=LOAD, in_ready=1, out_valid=0, out_last=0, busy=0, encoded_data=0, bit_count=0, both RSC states=0, QPP regs pi=0 g=(F1+F2) mod K.
- LOAD: bit written to buffer[bit_count] on in_valid&in_ready; bit_count++. On write of index K-1 -> ENCODE next cycle, in_ready=0, bit_count=0.
- ENCODE: word i presented with out_valid=1; held stable until out_ready. On accept, RSC states advance and i++.
  - sys = buffer[i]; p1 from RSC1 with u=buffer[i]; p2 from RSC2 with u=buffer[pi(i)].
  - RSC: a=u^s2^s3; parity=a^s1^s3; next state (a,s1,s2).
  - QPP recursive: pi(0)=0, pi(i+1)=(pi+g) mod K, g(i+1)=(g+2*F2) mod K. Mod done by conditional subtract; no multiplier.
  - After accept of i=K-1 -> TAIL.
- TAIL: 6 words, tail counter 0..5.
  - Words 0-2 terminate RSC1: u=s2^s3, word={u, s1^s3, 0}; RSC2 held.
  - Words 3-5 terminate RSC2: word={u2, 0, s1^s3 of RSC2}.
  - Word 5 has out_last=1. On its accept: back to LOAD, in_ready=1, RSC states cleared, QPP reset.
- Latency: first ENCODE word valid 1 cycle after last input bit accepted; throughput 1 word/cycle with out_ready=1.
- Backpressure: out_ready=0 freezes all ENCODE/TAIL state; in_valid ignored while in_ready=0.
- Both RSC states are 0 after TAIL; this is checked in simulation by assertion.
- Async reset mid-block discards the partial block; buffer contents need not be cleared.

Optional Feature:
TURBO_PUNCT_EN: adds input rate_half (1) and output encoded_mask (3).
- rate_half is sampled on entry to ENCODE.
- If sampled 1: ENCODE words get mask 3'b110 for even i, 3'b101 for odd i (rate 1/2).
- Otherwise, and for all TAIL words, mask=3'b111.
- Without the macro: ports absent, always rate 1/3, no mask logic.

Decomposition:
- Package turbo_pkg holds:
  - state enum {LOAD, ENCODE, TAIL}
  - generator constants G0=4'o13, G1=4'o15
  - TAIL_LEN=6
  - function qpp_step for the conditional-subtract modulo
- One sub-module rsc_encoder_k4 (state, advance, terminate mode), instanced twice.

Test Plan:
1. All-zero block (K=8) -> 8 words 3'b000, then 6 tail words 3'b000; out_last on the 14th word only.
2. Impulse at index 0 -> p1 and p2 both 1,1,1,1,0,0,1,0 (pi(0)=0); sys 1 then 0s. RSC1 tail {sys,p1}: (0,1),(1,0),(1,1).
3. Impulse at index 5 -> RSC2 impulse at i=1 since pi(1)=5; p2 = 0,1,1,1,1,0,0,1. Full permutation 0,5,6,3,4,1,2,7 checked via RSC2 input tap.
4. out_ready toggled 1/0 randomly across a block -> each word held stable while stalled; word sequence identical to the no-stall run; in_ready=0 throughout.
5. rst asserted on bit 4 of LOAD and again mid-ENCODE -> outputs return to reset values immediately; a fresh block then encodes correctly.
6. TURBO_PUNCT_EN with rate_half=1 -> masks 110,101,110,... for 8 words, then 111 for the 6 tail words; rate_half toggled mid-block has no effect.
